mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single 16-entry × 16-bit data memory of the memory stage between the CPU memory-stage port (port 0) and a secondary master such as a loader or debug port (port 1). It grants at most one access per cycle and drives the memory's address, write-data and write-enable. It routes registered read data back to the port that issued the read and supports bounded locked bursts.

## Interface

- AW, 4, address width (memory depth 2^AW)
- DW, 16, data width
- MAX_BURST, 4, maximum consecutive locked grants to one port before forced rotation (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request
- we0 / we1  in  1  1 = write, 0 = read; valid with req
- lock0 / lock1  in  1  request to keep grant on next cycle (burst)
- addr0 / addr1  in  AW  word address
- wd0 / wd1  in  DW  write data
- gnt0 / gnt1  out  1  combinational grant; access accepted when reqN && gntN
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds new read result
- rdata0 / rdata1  out  DW  registered read data; holds until next read completes for that port
- mem_addr  out  AW  memory address
- mem_wd  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data; valid the cycle after the address is presented with mem_we=0

## Operation

- At most one of gnt0/gnt1 high per cycle; gntN never high without reqN.
- Arbitration: one request → that port wins. Both requesting → port indicated by priority pointer `prio` wins, unless burst rule applies.
- `prio` updates on every accepted access to the non-winning port.
- Burst: if the winner had lockN=1 on its previous accepted access and reqN=1 now, it wins again regardless of `prio`. `burst_cnt` counts consecutive locked grants. When burst_cnt reaches MAX_BURST and the other port requests, the other port wins, and burst_cnt clears. burst_cnt also clears on any grant change or idle cycle.
- Memory drive: mem_addr/mem_wd mux from the granted port. mem_we = reqN && gntN && weN. With no grant, mem_we=0, mem_addr=addr0, mem_wd=wd0.
- Read tracking: 2-stage tag pipeline {valid, port}. Stage 1 records accepted reads at the granting edge. At the next edge, rdata[port] ← mem_rdata, and the rvalid[port] pulse goes high for the following cycle.
- Writes produce no rvalid.

## Timing

- Grant: combinational, same cycle as req. Write commits at the edge ending the grant cycle.
- Read latency: accepted in cycle N → mem_rdata valid in N+1 → rdataN/rvalidN in N+2. Back-to-back reads sustain 1 per cycle.
- Read of an address written in cycle N, issued in N+1: returns new data.
- Reset values: gnt0/gnt1=0 while rst, rvalid0/1=0, rdata0/1=0, mem_we=0, prio=port 0, burst_cnt=0, tag pipeline empty.
- Reset mid-operation: in-flight reads are discarded with no rvalid. The first grant after reset follows the reset prio.
- MAX_BURST=1: lock has no effect when both ports request.

## Structure

- Package mem_arb_pkg: PORT0/PORT1 index constants, read-tag struct {valid, port}, default AW/DW/MAX_BURST.
- Sub-module rr_arb2: 2-way round-robin grant with prio and lock/burst counter. The top level contains the datapath mux and the read-return pipeline.

## Test plan

- Reset, then req0 read addr 3 with mem[3]=0x1234 → gnt0 same cycle, rvalid0 pulse 2 cycles later, rdata0=0x1234, rvalid1 stays 0.
- req0 and req1 both write continuously, no lock → grants alternate 0,1,0,1. mem_we high every cycle, with mem_addr/mem_wd matching the granted port.
- lock1=1, req1 continuous, req0 continuous, MAX_BURST=4 → port 1 gets 4 consecutive grants, then port 0 is granted, then port 1 resumes.
- Port 0 writes 0xBEEF to addr 7, then port 1 reads addr 7 the next cycle → rdata1=0xBEEF, rvalid1 only.
- Reads accepted in cycles N and N+1, rst asserted in N+1 → no rvalid pulses, rdata0/1=0, gnt0/1=0 during reset.
- Interleaved reads port0 addr 1, port1 addr 2, port0 addr 3 → rvalid pulses in order 0,1,0 with the correct data each.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants and types for the two-port memory arbiter
package mem_arb_pkg;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int DEF_AW        = 4;
  localparam int DEF_DW        = 16;
  localparam int DEF_MAX_BURST = 4;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with bounded locked bursts
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic          prio_q, prio_d;
  logic          last_port_q, last_port_d;
  logic          last_lock_q, last_lock_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          hold;
  logic          win;

  always_comb begin
    gnt_o       = '0;
    prio_d      = prio_q;
    last_port_d = last_port_q;
    last_lock_d = last_lock_q;
    burst_cnt_d = '0;
    // A locked owner keeps the grant until its burst is spent and the other side is waiting.
    hold = last_lock_q && req_i[last_port_q] &&
           ((burst_cnt_q < CW'(MAX_BURST)) || !req_i[~last_port_q]);
    if (req_i == 2'b01)      win = PORT0;
    else if (req_i == 2'b10) win = PORT1;
    else if (hold)           win = last_port_q;
    else                     win = prio_q;

    if (!rst_i && (req_i != 2'b00)) begin
      gnt_o[win]  = 1'b1;
      prio_d      = ~win;
      last_port_d = win;
      last_lock_d = lock_i[win];
      if (!lock_i[win])
        burst_cnt_d = '0;
      else if (last_lock_q && (last_port_q == win))
        burst_cnt_d = (burst_cnt_q < CW'(MAX_BURST)) ? burst_cnt_q + CW'(1) : burst_cnt_q;
      else
        burst_cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q      <= PORT0;
      last_port_q <= PORT0;
      last_lock_q <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      prio_q      <= prio_d;
      last_port_q <= last_port_d;
      last_lock_q <= last_lock_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one data memory between two masters, returns read data per port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0]    gnt;
  rd_tag_t       tag1_q, tag1_d, tag2_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  rr_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  ({req1, req0}),
    .lock_i ({lock1, lock0}),
    .gnt_o  (gnt)
  );

  assign gnt0     = gnt[0];
  assign gnt1     = gnt[1];
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_wd   = gnt1 ? wd1 : wd0;
  assign mem_we   = (req0 && gnt0 && we0) || (req1 && gnt1 && we1);

  always_comb begin
    tag1_d       = '0;
    tag1_d.valid = (req0 && gnt0 && !we0) || (req1 && gnt1 && !we1);
    tag1_d.port  = gnt1 ? PORT1 : PORT0;
  end

  // Stage 1 waits for the memory's registered read; stage 2 is the rvalid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_q   <= '0;
      tag2_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag1_q;
      if (tag1_q.valid) begin
        if (tag1_q.port == PORT1) rdata1_q <= mem_rdata;
        else                      rdata0_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = tag2_q.valid && (tag2_q.port == PORT0);
  assign rvalid1 = tag2_q.valid && (tag2_q.port == PORT1);
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
